fetch_queue: RTL and testbench

Instruction fetch front end sitting directly upstream of the decode stage. Issues sequential 32-bit instruction requests to an instruction memory with variable response latency, buffers returned words with their PCs in a small FIFO, and presents them to decode through a valid/ready handshake. A redirect from the execute stage (taken branch/jump) flushes buffered and in-flight instructions and restarts fetch at the target.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions: machine width, PC step, NOP encoding and the
// {pc, inst} entry stored in the fetch FIFO.
package fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear and a registered head word, so the consumer
// sees a flop output rather than a read mux.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0) && !clear;
        do_push  = push && (count_q != FULL) && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        // Next head comes from storage unless it is the slot being written now.
        head_d = mem_q[rd_ptr_d];
        if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
        if (count_d == '0) head_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited sequential requests, in-order
// response buffering, and redirect flush with stale-response discard.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    push_entry, head_entry;
    logic            req_fire, push, pop;

    assign out_valid = (fifo_count != '0);

    always_comb begin
        // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
        imem_req_valid = !reset && !redirect_valid &&
                         (({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDIT);
        req_fire        = imem_req_valid && imem_req_ready;
        push            = imem_rsp_valid && !redirect_valid && (discard_q == '0);
        pop             = out_valid && out_ready && !redirect_valid;
        push_entry.pc   = rsp_pc_q;
        push_entry.inst = imem_rsp_data;

        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            rsp_pc_d   = align_pc(redirect_pc);
            // Everything still in flight after this cycle belongs to the old path.
            discard_d  = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (push)     rsp_pc_d   = rsp_pc_q + PC_STEP;
            if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect_valid),
        .count     (fifo_count),
        .head      (head_entry)
    );

    assign imem_req_addr = fetch_pc_q;
    assign out_pc        = head_entry.pc;
    assign out_inst      = head_entry.inst;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order variable-latency memory model plus a
// stream-level reference (decode must see consecutive PCs from each restart).
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, out_valid, out_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_pc, out_inst;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    int errors = 0;
    int checks = 0;
    int cyc, last_due, lat_min, lat_max;
    int unstable, occ, credit_viol;
    logic prev_stall, saw_rsp, saw_outv;
    logic [31:0] prev_addr;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] got_pc[$], got_inst[$], req_addr[$];
    int          got_cyc[$], req_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: memory answers, handshakes are logged, then the edge.
    task automatic tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
        saw_rsp  = imem_rsp_valid;
        saw_outv = out_valid;
        if (prev_stall && imem_req_valid && imem_req_addr !== prev_addr) unstable++;
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            int due;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
            req_addr.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
            occ++;
        end
        if (out_valid && out_ready && !redirect_valid && !reset) begin
            got_pc.push_back(out_pc);
            got_inst.push_back(out_inst);
            got_cyc.push_back(cyc);
            occ--;
        end
        if (occ > DEPTH) credit_viol++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        out_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        pend_addr.delete(); pend_due.delete();
        tick(); tick();
        reset = 1'b0;
        got_pc.delete(); got_inst.delete(); got_cyc.delete();
        req_addr.delete(); req_cyc.delete();
        cyc = 0; last_due = -1; unstable = 0; prev_stall = 1'b0; occ = 0; credit_viol = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid_during: got %b expected 0", imem_req_valid); end
        do_reset();
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_valid_after: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL rst_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_regs: got pc %h inst %h expected 0 0", out_pc, out_inst); end
        // Reset again while requests are in flight with slow memory.
        lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (6) tick();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (6) tick();
        checks++; if (got_pc[0] !== 32'h0 || got_inst[0] !== mem_word(32'h0)) begin errors++; $display("FAIL rst_mid_restart: got pc %h inst %h expected 0 %h", got_pc[0], got_inst[0], mem_word(32'h0)); end
    endtask

    task automatic test_sequential();
        int bad;
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (22) tick();
        checks++; if (got_cyc[0] !== 2 || got_pc[0] !== 32'h0) begin errors++; $display("FAIL seq_first: got cyc %0d pc %h expected cyc 2 pc 0", got_cyc[0], got_pc[0]); end
        checks++; if (got_cyc[1] !== 3 || got_pc[1] !== 32'h4) begin errors++; $display("FAIL seq_second: got cyc %0d pc %h expected cyc 3 pc 4", got_cyc[1], got_pc[1]); end
        checks++; if (req_cyc[0] !== 0 || req_addr[2] !== 32'h8) begin errors++; $display("FAIL seq_req: got cyc %0d addr2 %h expected 0 8", req_cyc[0], req_addr[2]); end
        checks++; if (got_pc.size() !== 20) begin errors++; $display("FAIL seq_throughput: got %0d expected 20", got_pc.size()); end
        bad = 0;
        for (int i = 0; i < got_pc.size(); i++)
            if (got_pc[i] !== 32'(4*i) || got_inst[i] !== mem_word(32'(4*i))) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL seq_stream: got %0d bad entries expected 0", bad); end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        repeat (10) tick();
        #1;
        checks++; if (req_addr.size() !== DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d expected %0d", req_addr.size(), DEPTH); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== mem_word(32'h0)) begin errors++; $display("FAIL bp_head: got v %b pc %h inst %h expected 1 0 %h", out_valid, out_pc, out_inst, mem_word(32'h0)); end
        out_ready = 1'b1;
        repeat (12) tick();
        checks++; if (got_pc.size() !== 12) begin errors++; $display("FAIL bp_drain_count: got %0d expected 12", got_pc.size()); end
        bad = 0;
        for (int i = 0; i < got_pc.size(); i++)
            if (got_pc[i] !== 32'(4*i) || got_inst[i] !== mem_word(32'(4*i)) || got_cyc[i] != 10 + i) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_drain_order: got %0d bad entries expected 0", bad); end
    endtask

    task automatic test_redirect_lat3();
        int bad;
        do_reset();
        lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (req_addr.size() !== 3) begin errors++; $display("FAIL rd3_outstanding: got %0d expected 3", req_addr.size()); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd3_req_blocked: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        repeat (16) tick();
        checks++; if (req_addr[3] !== 32'h100 || req_cyc[3] !== 4) begin errors++; $display("FAIL rd3_new_req: got %h at %0d expected 100 at 4", req_addr[3], req_cyc[3]); end
        checks++; if (got_pc[0] !== 32'h100 || got_inst[0] !== mem_word(32'h100) || got_cyc[0] !== 8) begin errors++; $display("FAIL rd3_first: got pc %h inst %h cyc %0d expected 100 %h 8", got_pc[0], got_inst[0], got_cyc[0], mem_word(32'h100)); end
        checks++; if (got_pc[1] !== 32'h104 || got_inst[1] !== mem_word(32'h104)) begin errors++; $display("FAIL rd3_second: got pc %h inst %h expected 104 %h", got_pc[1], got_inst[1], mem_word(32'h104)); end
        bad = (got_pc.size() < 3) ? 1 : 0;
        for (int i = 0; i < got_pc.size(); i++)
            if (got_pc[i] !== 32'h100 + 32'(4*i) || got_inst[i] !== mem_word(got_pc[i])) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rd3_stream: got %0d bad entries expected 0", bad); end
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        checks++; if (saw_rsp !== 1'b1 || saw_outv !== 1'b1) begin errors++; $display("FAIL rdc_coincide: got rsp %b outv %b expected 1 1", saw_rsp, saw_outv); end
        repeat (8) tick();
        checks++; if (req_addr[5] !== 32'h200 || req_cyc[5] !== 6) begin errors++; $display("FAIL rdc_new_req: got %h at %0d expected 200 at 6", req_addr[5], req_cyc[5]); end
        checks++; if (got_pc.size() !== 9 || got_pc[2] !== 32'h8) begin errors++; $display("FAIL rdc_count: got %0d entries pc2 %h expected 9 8", got_pc.size(), got_pc[2]); end
        checks++; if (got_pc[3] !== 32'h200 || got_inst[3] !== mem_word(32'h200) || got_cyc[3] !== 8) begin errors++; $display("FAIL rdc_first: got pc %h inst %h cyc %0d expected 200 %h 8", got_pc[3], got_inst[3], got_cyc[3], mem_word(32'h200)); end
        checks++; if (got_pc[4] !== 32'h204 || got_inst[4] !== mem_word(32'h204)) begin errors++; $display("FAIL rdc_second: got pc %h expected 204", got_pc[4]); end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        checks++; if (got_pc[0] !== 32'hFFFF_FFF8 || got_inst[0] !== mem_word(32'hFFFF_FFF8)) begin errors++; $display("FAIL wrap_0: got %h expected fffffff8", got_pc[0]); end
        checks++; if (got_pc[1] !== 32'hFFFF_FFFC || got_inst[1] !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_1: got %h expected fffffffc", got_pc[1]); end
        checks++; if (got_pc[2] !== 32'h0 || got_inst[2] !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_2: got %h expected 00000000", got_pc[2]); end
    endtask

    task automatic test_random_ready();
        int bad;
        do_reset();
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(1, 0) == 1);
            out_ready      = ($urandom_range(9, 0) < 7);
            tick();
        end
        imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (20) tick();
        checks++; if (unstable !== 0) begin errors++; $display("FAIL rnd_addr_stable: got %0d changes expected 0", unstable); end
        checks++; if (credit_viol !== 0) begin errors++; $display("FAIL rnd_credit: got %0d violations expected 0", credit_viol); end
        checks++; if (got_pc.size() < 50 || got_pc.size() + DEPTH < req_addr.size()) begin errors++; $display("FAIL rnd_progress: got %0d delivered of %0d requested", got_pc.size(), req_addr.size()); end
        bad = 0;
        for (int i = 0; i < got_pc.size(); i++)
            if (got_pc[i] !== 32'(4*i) || got_inst[i] !== mem_word(32'(4*i))) bad++;
        for (int i = 0; i < req_addr.size(); i++)
            if (req_addr[i] !== 32'(4*i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd_stream: got %0d bad entries expected 0", bad); end
    endtask

    task automatic test_random_redirect();
        logic [31:0] exp_pc, tgt;
        logic        redir;
        int          seen, nfail;
        do_reset();
        lat_min = 1; lat_max = 3;
        exp_pc = RESET_PC; seen = 0; nfail = 0;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            out_ready      = ($urandom_range(3, 0) != 0);
            redir          = ($urandom_range(15, 0) == 0);
            tgt            = $urandom();
            redirect_valid = redir;
            redirect_pc    = tgt;
            tick();
            redirect_valid = 1'b0;
            while (seen < got_pc.size()) begin
                checks++;
                if (got_pc[seen] !== exp_pc || got_inst[seen] !== mem_word(exp_pc)) begin
                    errors++; nfail++;
                    if (nfail <= 5) $display("FAIL rr_stream: got pc %h inst %h expected %h %h", got_pc[seen], got_inst[seen], exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
            if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
        end
        checks++; if (seen < 30) begin errors++; $display("FAIL rr_progress: got %0d delivered expected at least 30", seen); end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        lat_min = 1; lat_max = 1; cyc = 0; last_due = -1;
        unstable = 0; occ = 0; credit_viol = 0; prev_stall = 1'b0; prev_addr = 32'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_lat3();
        test_redirect_coincident();
        test_wrap();
        test_random_ready();
        test_random_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
